vga_rx_monitor: RTL and testbench

VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

---
 rtl/vga_rx_monitor.sv | 207 ++++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_monitor.sv
// Passive VGA timing monitor: locks onto the h/v sync cadence, flags timing faults, captures visible pixels.
// Pixel to capture is two pix_en ticks (input reg + output reg); no backpressure, captures are single-clk pulses.
module vga_rx_monitor #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic        h_sync,
   input  logic        v_sync,
   input  logic [3:0]  Red,
   input  logic [3:0]  Green,
   input  logic [3:0]  Blue,
   input  logic        err_clr,
   output logic [9:0]  cap_x,
   output logic [9:0]  cap_y,
   output logic [11:0] cap_rgb,
   output logic        cap_valid,
   output logic        frame_start,
   output logic        locked,
   output logic        err
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] LP_H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] LP_H_END  = 11'(H_TOTAL);
   localparam logic [10:0] LP_H_VIS0 = 11'(H_SYNC + H_BP);
   localparam logic [10:0] LP_H_VIS1 = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [9:0]  LP_V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  LP_V_END  = 10'(V_TOTAL);
   localparam logic [9:0]  LP_V_VIS0 = 10'(V_SYNC + V_BP);
   localparam logic [9:0]  LP_V_VIS1 = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_bad;
   logic        w_bad_nxt;

   logic        r_hs;
   logic        r_vs;
   logic        r_hs_d;
   logic        r_vs_d;
   logic [11:0] r_rgb;

   logic [10:0] r_hcnt;
   logic [10:0] w_hcnt_inc;
   logic [10:0] w_hcnt_nxt;
   logic [9:0]  r_vcnt;
   logic [9:0]  w_vcnt_inc;
   logic [9:0]  w_vcnt_nxt;

   logic        w_hs_fall;
   logic        w_vs_fall;
   logic        w_h_bad;
   logic        w_v_bad;
   logic        w_err_cond;
   logic        w_err_evt;
   logic        w_vis;
   logic        w_cap;
   logic [9:0]  w_xpos;
   logic [9:0]  w_ypos;

   logic [9:0]  r_cap_x;
   logic [9:0]  r_cap_y;
   logic [11:0] r_cap_rgb;
   logic        r_cap_vld;
   logic        r_frame_start;
   logic        r_err;

   // Everything downstream sees only the registered copy; r_*_d is the previous tick's sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hs   <= 1'b1;
         r_vs   <= 1'b1;
         r_hs_d <= 1'b1;
         r_vs_d <= 1'b1;
         r_rgb  <= '0;
      end else if (pix_en) begin
         r_hs   <= h_sync;
         r_vs   <= v_sync;
         r_hs_d <= r_hs;
         r_vs_d <= r_vs;
         r_rgb  <= {Red, Green, Blue};
      end
   end

   assign w_hs_fall  = r_hs_d & ~r_hs;
   assign w_vs_fall  = r_vs_d & ~r_vs;

   assign w_hcnt_inc = (r_hcnt == 11'h7FF) ? r_hcnt : r_hcnt + 11'd1;
   assign w_vcnt_inc = (r_vcnt == 10'h3FF) ? r_vcnt : r_vcnt + 10'd1;
   assign w_hcnt_nxt = w_hs_fall ? 11'd0 : w_hcnt_inc;
   assign w_vcnt_nxt = w_vs_fall ? 10'd0 : (w_hs_fall ? w_vcnt_inc : r_vcnt);

   // A sync edge is judged against the count of the pixel just before it.
   assign w_h_bad    = w_hs_fall && (r_hcnt != LP_H_LAST);
   assign w_v_bad    = w_vs_fall && (r_vcnt != LP_V_LAST);
   assign w_err_cond = w_h_bad || w_v_bad || (w_hcnt_nxt == LP_H_END) || (w_vcnt_nxt == LP_V_END);
   assign w_err_evt  = pix_en && (r_state == ST_LOCKED) && w_err_cond;

   assign w_vis  = (w_hcnt_nxt >= LP_H_VIS0) && (w_hcnt_nxt <= LP_H_VIS1) &&
                   (w_vcnt_nxt >= LP_V_VIS0) && (w_vcnt_nxt <= LP_V_VIS1);
   assign w_xpos = 10'(w_hcnt_nxt - LP_H_VIS0);
   assign w_ypos = w_vcnt_nxt - LP_V_VIS0;
   assign w_cap  = pix_en && (r_state == ST_LOCKED) && !w_err_cond && w_vis;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (pix_en) begin
         r_hcnt <= w_hcnt_nxt;
         r_vcnt <= w_vcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bad_nxt   = r_bad;
      case (r_state)
         ST_SEARCH: begin
            if (w_vs_fall) begin
               w_state_nxt = ST_ACQ;
               w_bad_nxt   = 1'b0;
            end
         end
         ST_ACQ: begin
            // r_bad remembers any mis-timed line since the frame began.
            if (w_vs_fall) begin
               if (!r_bad && !w_h_bad && !w_v_bad) begin
                  w_state_nxt = ST_LOCKED;
               end
               w_bad_nxt = 1'b0;
            end else if (w_h_bad) begin
               w_bad_nxt = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (w_err_cond) begin
               w_state_nxt = ST_SEARCH;
            end
         end
         default: begin
            w_state_nxt = ST_SEARCH;
            w_bad_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_SEARCH;
         r_bad   <= 1'b0;
      end else if (pix_en) begin
         r_state <= w_state_nxt;
         r_bad   <= w_bad_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cap_x       <= '0;
         r_cap_y       <= '0;
         r_cap_rgb     <= '0;
         r_cap_vld     <= 1'b0;
         r_frame_start <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_cap_vld     <= w_cap;
         r_frame_start <= w_cap && (w_xpos == 10'd0) && (w_ypos == 10'd0);
         if (w_cap) begin
            r_cap_x   <= w_xpos;
            r_cap_y   <= w_ypos;
            r_cap_rgb <= r_rgb;
         end
         if (w_err_evt) begin
            r_err <= 1'b1;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign cap_x       = r_cap_x;
   assign cap_y       = r_cap_y;
   assign cap_rgb     = r_cap_rgb;
   assign cap_valid   = r_cap_vld;
   assign frame_start = r_frame_start;
   assign locked      = (r_state == ST_LOCKED);
   assign err         = r_err;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor: reduced raster, random pix_en spacing, pixel-level reference model.
module tb_vga_rx_monitor;

   localparam int HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int VA = 4, VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pix_en = 1'b0;
   logic        h_sync = 1'b1;
   logic        v_sync = 1'b1;
   logic [3:0]  Red = '0, Green = '0, Blue = '0;
   logic        err_clr = 1'b0;
   logic [9:0]  cap_x, cap_y;
   logic [11:0] cap_rgb;
   logic        cap_valid, frame_start, locked, err;

   vga_rx_monitor #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync),
      .Red(Red), .Green(Green), .Blue(Blue), .err_clr(err_clr),
      .cap_x(cap_x), .cap_y(cap_y), .cap_rgb(cap_rgb), .cap_valid(cap_valid),
      .frame_start(frame_start), .locked(locked), .err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int n_cap = 0;
   int n_fs  = 0;
   int f_x = -1, f_y = -1;
   bit g_rand_rgb = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: each pixel is classified when presented; its effects show one tick later.
   int          m_hc, m_vc, m_st;      // m_st: 0 search, 1 acquiring, 2 locked
   bit          m_ph, m_pv, m_bad;
   bit          pr_vld, pr_fs, pr_err;
   int          pr_x, pr_y;
   logic [11:0] pr_rgb;
   bit          e_vld, e_fs, e_locked, e_err;
   int          e_x, e_y;
   logic [11:0] e_rgb;

   task automatic m_pixel(input bit h, input bit v, input logic [11:0] c);
      bit hf, vf, hbad, vbad, ev;
      int ohc, ovc, x, y;
      hf = m_ph && !h;
      vf = m_pv && !v;
      m_ph = h;
      m_pv = v;
      ohc = m_hc;
      ovc = m_vc;
      m_hc = hf ? 0 : ((m_hc < 2047) ? m_hc + 1 : 2047);
      if (vf) m_vc = 0;
      else if (hf && m_vc < 1023) m_vc = m_vc + 1;
      hbad = hf && (ohc != HT - 1);
      vbad = vf && (ovc != VT - 1);
      ev = (m_st == 2) && (hbad || vbad || m_hc == HT || m_vc == VT);
      x = m_hc - (HS + HB);
      y = m_vc - (VS + VB);
      pr_vld = (m_st == 2) && !ev && x >= 0 && x < HA && y >= 0 && y < VA;
      pr_fs  = pr_vld && x == 0 && y == 0;
      pr_x = x; pr_y = y; pr_rgb = c; pr_err = ev;
      if (ev) m_st = 0;
      else if (m_st == 0) begin
         if (vf) begin m_st = 1; m_bad = 0; end
      end else if (m_st == 1) begin
         if (vf) begin
            if (!m_bad && !hbad && !vbad) m_st = 2;
            m_bad = 0;
         end else if (hbad) m_bad = 1;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_ph = 1; m_pv = 1; m_hc = 0; m_vc = 0; m_st = 0; m_bad = 0;
            e_vld = 0; e_fs = 0; e_locked = 0; e_err = 0; e_x = 0; e_y = 0; e_rgb = '0;
            m_pixel(1'b1, 1'b1, 12'h000);   // the reset contents of the input register
         end else begin
            e_vld = 0;
            e_fs  = 0;
            if (pix_en) begin
               e_locked = (m_st == 2);
               if (pr_err) e_err = 1;
               else if (err_clr) e_err = 0;
               if (pr_vld) begin
                  e_vld = 1; e_fs = pr_fs; e_x = pr_x; e_y = pr_y; e_rgb = pr_rgb;
               end
               m_pixel(h_sync, v_sync, {Red, Green, Blue});
            end else if (err_clr) begin
               e_err = 0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("cap_valid", cap_valid, e_vld);
         chk("frame_start", frame_start, e_fs);
         chk("locked", locked, e_locked);
         chk("err", err, e_err);
         chk("cap_x", cap_x, e_x);
         chk("cap_y", cap_y, e_y);
         chk("cap_rgb", cap_rgb, e_rgb);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cap_valid) begin
            if (n_cap == 0) begin f_x = cap_x; f_y = cap_y; end
            n_cap++;
         end
         if (frame_start) n_fs++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [11:0] pat(input int x, input int y);
      logic [9:0] xx, yy;
      xx = 10'(x);
      yy = 10'(y);
      return {xx[3:0], yy[3:0], xx[7:4]};
   endfunction

   // Entered and left at posedge+2; pix_en is low between pixels and junk is driven meanwhile.
   task automatic send_pixel(input logic hs, input logic vs, input logic [11:0] c, input logic clr);
      int gap;
      pix_en = 1'b1; h_sync = hs; v_sync = vs; {Red, Green, Blue} = c; err_clr = clr;
      @(posedge clk); #2;
      pix_en = 1'b0; err_clr = 1'b0;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
         h_sync = 1'($urandom); v_sync = 1'($urandom); {Red, Green, Blue} = 12'($urandom);
         @(posedge clk); #2;
      end
   endtask

   task automatic clr_counts();
      n_cap = 0; n_fs = 0; f_x = -1; f_y = -1;
   endtask

   task automatic send_frame(input int bad_line, input int delta, input int rst_pix, input int clr_pix);
      int idx, len, x, y;
      logic hs, vs;
      logic [11:0] c;
      idx = 0;
      for (int l = 0; l < VT; l++) begin
         len = (l == bad_line) ? HT + delta : HT;
         for (int p = 0; p < len; p++) begin
            if (idx == rst_pix) begin
               rst = 1'b0;
               #1;
               chk("rst_cap_valid", cap_valid, 0);
               chk("rst_frame_start", frame_start, 0);
               chk("rst_locked", locked, 0);
               chk("rst_err", err, 0);
               chk("rst_cap_x", cap_x, 0);
               chk("rst_cap_y", cap_y, 0);
               chk("rst_cap_rgb", cap_rgb, 0);
               @(posedge clk); #2;
               rst = 1'b1;
               clr_counts();
            end
            hs = (p >= HS);
            vs = (l >= VS);
            x = p - (HS + HB);
            y = l - (VS + VB);
            if (!g_rand_rgb && x >= 0 && x < HA && y >= 0 && y < VA) c = pat(x, y);
            else c = 12'($urandom);
            send_pixel(hs, vs, c, idx == clr_pix);
            idx++;
         end
      end
   endtask

   initial begin
      int bl, d, cp;
      repeat (3) @(posedge clk);
      #2;
      chk("init_locked", locked, 0);
      chk("init_cap_valid", cap_valid, 0);
      chk("init_err", err, 0);
      rst = 1'b1;

      clr_counts(); send_frame(-1, 0, -1, -1);
      chk("f1_locked", locked, 0);
      chk("f1_caps", n_cap, 0);
      clr_counts(); send_frame(-1, 0, -1, -1);
      chk("f2_locked", locked, 1);
      chk("f2_caps", n_cap, 32);
      chk("f2_fs", n_fs, 1);
      chk("f2_first_x", f_x, 0);
      chk("f2_first_y", f_y, 0);
      clr_counts(); send_frame(-1, 0, -1, -1);
      chk("f3_caps", n_cap, 32);
      chk("f3_fs", n_fs, 1);

      // line 5 one tick short: error at the start of line 6, after 16 captures
      clr_counts(); send_frame(5, -1, -1, -1);
      chk("short_err", err, 1);
      chk("short_locked", locked, 0);
      chk("short_caps", n_cap, 16);
      clr_counts(); send_frame(-1, 0, -1, -1);
      chk("acq_locked", locked, 0);
      chk("acq_caps", n_cap, 0);
      clr_counts(); send_frame(-1, 0, -1, -1);
      chk("relock_locked", locked, 1);
      chk("relock_caps", n_cap, 32);
      chk("err_sticky", err, 1);
      clr_counts(); send_frame(-1, 0, -1, 10);
      chk("clr_err", err, 0);

      // err_clr on the very tick that registers the short-line error
      send_frame(5, -1, -1, 6 * HT);
      chk("clr_vs_set_err", err, 1);
      chk("clr_vs_set_locked", locked, 0);
      send_frame(-1, 0, -1, -1);
      send_frame(-1, 0, -1, 10);
      chk("pre_stuck_locked", locked, 1);
      chk("pre_stuck_err", err, 0);

      // syncs stuck high: the first extra pixel reaches hcnt = H_TOTAL
      send_pixel(1'b1, 1'b1, 12'h000, 1'b0);
      chk("stuck1_locked", locked, 1);
      chk("stuck1_err", err, 0);
      send_pixel(1'b1, 1'b1, 12'h000, 1'b0);
      chk("stuck2_locked", locked, 0);
      chk("stuck2_err", err, 1);
      repeat (5) send_pixel(1'b1, 1'b1, 12'h000, 1'b0);

      send_frame(-1, 0, -1, -1);
      send_frame(-1, 0, -1, -1);
      chk("prerst_locked", locked, 1);
      send_frame(-1, 0, 5 * HT + 10, -1);
      chk("postrst_caps", n_cap, 0);
      clr_counts(); send_frame(-1, 0, -1, -1);
      chk("postrst_acq_locked", locked, 0);
      chk("postrst_acq_caps", n_cap, 0);
      clr_counts(); send_frame(-1, 0, -1, -1);
      chk("postrst_relock", locked, 1);
      chk("postrst_caps_full", n_cap, 32);

      g_rand_rgb = 1'b1;
      for (int f = 0; f < 12; f++) begin
         bl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, VT - 1)) : -1;
         d  = int'($urandom_range(1, 2));
         if ($urandom_range(0, 1) == 1) d = -d;
         cp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, HT * VT - 20)) : -1;
         send_frame(bl, d, -1, cp);
      end
      repeat (4) @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
